// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN input-image RAM read path.
package cnn_pkg;

  localparam int IMG_W     = 28;
  localparam int WIN_BEATS = 9;
  localparam int RAM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cnn_rr_pick2.sv
// Two-way round-robin pick with its favour pointer; the pointer only advances
// when both candidates compete, so a lone or ineligible requester never consumes it.
module cnn_rr_pick2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] cand,
  input  logic       load,
  input  logic       load_fav,
  output logic       pick_vld,
  output logic       pick_sel
);

  logic fav_q, fav_d;

  always_comb begin
    pick_vld = en & (|cand);
    pick_sel = (&cand) ? fav_q : cand[1];
    fav_d    = fav_q;
    if (clr) begin
      fav_d = 1'b0;
    end else if (load) begin
      fav_d = load_fav;
    end else if (en && (&cand)) begin
      fav_d = ~fav_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fav_q <= 1'b0;
    end else begin
      fav_q <= fav_d;
    end
  end

endmodule

// File: rtl/cnn_ram_rd_arb.sv
// Read-port arbiter and read-after-write guard for the 1-bit input image RAM.
// Define CNN_RAM_RD_ARB_WDOG_EN to add the lock watchdog and its wdog_err port.
module cnn_ram_rd_arb
  import cnn_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = RAM_DEPTH,
  parameter int BURST_MAX = WIN_BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_stb,
  input  logic              rq0_req,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic              rq0_last,
  output logic              rq0_gnt,
  input  logic              rq1_req,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic              rq1_last,
  output logic              rq1_gnt,
  output logic [ADDR_W-1:0] ram_addr_rd,
  input  logic              ram_dout,
  output logic              rd_data,
  output logic              rd_vld0,
  output logic              rd_vld1,
  output logic [ADDR_W:0]   wr_ptr
`ifdef CNN_RAM_RD_ARB_WDOG_EN
  ,
  output logic              wdog_err
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  arb_state_t        state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        tag_q, tag_d;
  logic [1:0]        vld_q, vld_d;
  logic              rd_data_q, rd_data_d;
  logic [1:0]        gnt;
  logic              elig0, elig1, sel_last;
  logic              pick_vld, pick_sel, ptr_load, ptr_load_fav;

`ifdef CNN_RAM_RD_ARB_WDOG_EN
  localparam int WDOG_LIM = 4 * BURST_MAX;
  localparam int WDOG_W   = $clog2(WDOG_LIM + 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
`endif

  // Eligibility looks at the pointer before this cycle's write lands.
  assign elig0    = ({1'b0, rq0_addr} < wr_ptr_q);
  assign elig1    = ({1'b0, rq1_addr} < wr_ptr_q);
  assign sel_last = pick_sel ? rq1_last : rq0_last;

  cnn_rr_pick2 u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .en       (state_q == IDLE),
    .cand     ({rq1_req & elig1, rq0_req & elig0}),
    .load     (ptr_load),
    .load_fav (ptr_load_fav),
    .pick_vld (pick_vld),
    .pick_sel (pick_sel)
  );

  always_comb begin
    state_d      = state_q;
    gnt          = 2'b00;
    ptr_load     = 1'b0;
    ptr_load_fav = 1'b0;
`ifdef CNN_RAM_RD_ARB_WDOG_EN
    wdog_cnt_d   = '0;
    wdog_err_d   = wdog_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt[pick_sel] = 1'b1;
          if (!sel_last) state_d = pick_sel ? LOCK1 : LOCK0;
        end
      end
      LOCK0: begin
        if (rq0_req && elig0) begin
          gnt[0] = 1'b1;
          if (rq0_last) state_d = IDLE;
        end
      end
      LOCK1: begin
        if (rq1_req && elig1) begin
          gnt[1] = 1'b1;
          if (rq1_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef CNN_RAM_RD_ARB_WDOG_EN
    // A lock that outlives the budget is broken and the other side favoured.
    if (state_q != IDLE && state_d != IDLE) begin
      if (wdog_cnt_q == WDOG_W'(WDOG_LIM - 1)) begin
        state_d      = IDLE;
        wdog_err_d   = 1'b1;
        ptr_load     = 1'b1;
        ptr_load_fav = (state_q == LOCK0);
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
    end
    if (clr) begin
      wdog_cnt_d = '0;
      wdog_err_d = 1'b0;
    end
`endif
    if (clr) begin
      state_d = IDLE;
      gnt     = 2'b00;
    end

    ram_addr_rd = gnt[0] ? rq0_addr : (gnt[1] ? rq1_addr : addr_q);
    addr_d      = clr ? '0 : ram_addr_rd;
    tag_d       = gnt;
    vld_d       = clr ? 2'b00 : tag_q;
    rd_data_d   = clr ? 1'b0 : ram_dout;

    wr_ptr_d = wr_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
    end else if (wr_stb && (wr_ptr_q != DEPTH_C)) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      addr_q    <= '0;
      tag_q     <= 2'b00;
      vld_q     <= 2'b00;
      rd_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
      vld_q     <= vld_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef CNN_RAM_RD_ARB_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end
  assign wdog_err = wdog_err_q;
`endif

  assign rq0_gnt = gnt[0];
  assign rq1_gnt = gnt[1];
  assign rd_data = rd_data_q;
  assign rd_vld0 = vld_q[0];
  assign rd_vld1 = vld_q[1];
  assign wr_ptr  = wr_ptr_q;

endmodule
